// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron: register map, reset defaults, FSM states
// and 8-bit saturating helpers.
package lif_pkg;

  localparam logic [3:0] AddrWeight   = 4'h0;
  localparam logic [3:0] AddrThresh   = 4'h1;
  localparam logic [3:0] AddrLeak     = 4'h2;
  localparam logic [3:0] AddrLeakPer  = 4'h3;
  localparam logic [3:0] AddrRefract  = 4'h4;
  localparam logic [3:0] AddrCtrl     = 4'h5;
  localparam logic [3:0] AddrMembrane = 4'h8;
  localparam logic [3:0] AddrStatus   = 4'h9;
  localparam logic [3:0] AddrSpikeCnt = 4'hA;

  localparam logic [7:0] WeightRst  = 8'd20;
  localparam logic [7:0] ThreshRst  = 8'd100;
  localparam logic [7:0] LeakRst    = 8'd1;
  localparam logic [7:0] LeakPerRst = 8'd16;
  localparam logic [7:0] RefractRst = 8'd4;
  localparam logic       EnableRst  = 1'b1;

  typedef enum logic [1:0] {StIdle, StIntegrate, StRefract} lif_state_e;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'h00;
  endfunction

endpackage

// File: rtl/lif_neuron_if.sv
// TinyQV-style register bus between a host (master) and the neuron (slave).
interface lif_neuron_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/lif_leak_timer.sv
// Leak period counter: ticks once every period_i cycles while enabled; period 0 disables.
module lif_leak_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             restart_i,
  input  logic [Width-1:0] period_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             at_end;

  always_comb begin
    at_end = (period_i != '0) && (cnt_q == period_i - Width'(1));
    cnt_d  = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (en_i && (period_i != '0)) begin
      cnt_d = at_end ? '0 : cnt_q + Width'(1);
    end
  end

  // A period rewrite restarts the count, so the old period's tick is dropped.
  assign tick_o = en_i && !restart_i && at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: register file, saturating membrane arithmetic and
// the IDLE/INTEGRATE/REFRACTORY control FSM.
module lif_neuron import lif_pkg::*; #(
  parameter int unsigned LEAK_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spike_in,
  lif_neuron_if.slave  bus,
  output logic [7:0]   uo_out
);

  logic [7:0] weight_q, thresh_q, leak_q, leak_per_q, refract_q;
  logic       en_q;
  logic [7:0] mem_q, mem_d, cnt_q, cnt_d, ref_q, ref_d;
  logic       sticky_q, sticky_d, fire_q, fire_d;
  lif_state_e state_q, state_d;

  logic [7:0]        v1, v2;
  logic              clr, leak_restart, leak_tick, in_refract;
  logic [LEAK_W-1:0] leak_per_w;

  assign clr          = bus.data_write && (bus.address == AddrCtrl) && bus.data_in[1];
  assign leak_restart = bus.data_write && (bus.address == AddrLeakPer);
  assign leak_per_w   = LEAK_W'(leak_per_q);
  assign in_refract   = (state_q == StRefract);

  lif_leak_timer #(
    .Width (LEAK_W)
  ) u_leak_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en_q),
    .restart_i (leak_restart),
    .period_i  (leak_per_w),
    .tick_o    (leak_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q   <= WeightRst;
      thresh_q   <= ThreshRst;
      leak_q     <= LeakRst;
      leak_per_q <= LeakPerRst;
      refract_q  <= RefractRst;
      en_q       <= EnableRst;
    end else if (bus.data_write) begin
      case (bus.address)
        AddrWeight:  weight_q   <= bus.data_in;
        AddrThresh:  thresh_q   <= bus.data_in;
        AddrLeak:    leak_q     <= bus.data_in;
        AddrLeakPer: leak_per_q <= bus.data_in;
        AddrRefract: refract_q  <= bus.data_in;
        AddrCtrl:    en_q       <= bus.data_in[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIntegrate;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    ref_d    = ref_q;
    fire_d   = 1'b0;
    // A clear coincident with a fire still counts that fire.
    cnt_d    = clr ? 8'h00 : cnt_q;
    sticky_d = clr ? 1'b0 : sticky_q;
    v1       = spike_in ? sat_add8(mem_q, weight_q) : mem_q;
    v2       = leak_tick ? sat_sub8(v1, leak_q) : v1;
    if (!en_q) begin
      state_d = StIdle;
      ref_d   = 8'h00;
    end else begin
      unique case (state_q)
        StIdle, StIntegrate: begin
          if (v2 >= thresh_q) begin
            mem_d    = 8'h00;
            fire_d   = 1'b1;
            cnt_d    = sat_add8(cnt_d, 8'd1);
            sticky_d = 1'b1;
            ref_d    = refract_q;
            state_d  = (refract_q == 8'd0) ? StIntegrate : StRefract;
          end else begin
            mem_d   = v2;
            state_d = StIntegrate;
          end
        end
        StRefract: begin
          mem_d = 8'h00;
          if (ref_q <= 8'd1) begin
            ref_d   = 8'h00;
            state_d = StIntegrate;
          end else begin
            ref_d = ref_q - 8'd1;
          end
        end
        default: state_d = StIntegrate;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= 8'h00;
      cnt_q    <= 8'h00;
      ref_q    <= 8'h00;
      sticky_q <= 1'b0;
      fire_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      sticky_q <= sticky_d;
      fire_q   <= fire_d;
    end
  end

  always_comb begin
    uo_out       = {5'b0, en_q, in_refract, fire_q};
    bus.data_out = 8'h00;
    case (bus.address)
      AddrWeight:   bus.data_out = weight_q;
      AddrThresh:   bus.data_out = thresh_q;
      AddrLeak:     bus.data_out = leak_q;
      AddrLeakPer:  bus.data_out = leak_per_q;
      AddrRefract:  bus.data_out = refract_q;
      AddrCtrl:     bus.data_out = {7'b0, en_q};
      AddrMembrane: bus.data_out = mem_q;
      AddrStatus:   bus.data_out = {6'b0, in_refract, sticky_q};
      AddrSpikeCnt: bus.data_out = cnt_q;
      default: ;
    endcase
  end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron peripheral that consumes the 1-bit spike stream produced by the spike encoder stage and turns it into output firing events. Each sampled spike adds a programmable weight to an 8-bit membrane potential, which leaks on a programmable period. When the potential reaches threshold, the neuron fires a one-cycle pulse and enters a refractory window. Configuration and status sit behind the same TinyQV register interface as the encoder.

## Interface
- `LEAK_W`, default 8: width of the leak-period counter.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spike_in`  in  1  level spike from upstream encoder (its `uo_out[0]`); sampled every rising edge.
- `address`  in  4  register address.
- `data_write`  in  1  write strobe, single cycle.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data, combinational from `address`.
- `uo_out`  out  8  `[0]` fire pulse, `[1]` refractory, `[2]` enable, `[7:3]` 0.

## Operation
- Register map:
  - 0x0 WEIGHT, reset 20.
  - 0x1 THRESH, reset 100.
  - 0x2 LEAK, reset 1.
  - 0x3 LEAK_PER, reset 16; 0 disables leak.
  - 0x4 REFRACT, reset 4.
  - 0x5 CTRL: bit0 enable (reset 1), bit1 write-1 clears SPIKE_CNT and sticky flag, self-clearing, reads 0.
  - 0x8 MEMBRANE, read-only.
  - 0x9 STATUS `{6'b0, refractory, fired_sticky}`, read-only.
  - 0xA SPIKE_CNT, read-only, counts fires.
  - Unmapped addresses read 0.
  - Writes to read-only or unmapped addresses are ignored.
- States:
  - IDLE (enable=0): membrane held, leak timer held, spikes ignored.
  - INTEGRATE.
  - REFRACTORY.
- INTEGRATE, each edge, evaluated in this order:
  - v1 = spike_in ? min(v + WEIGHT, 255) : v.
  - v2 = leak_tick ? max(v1 − LEAK, 0) : v1.
  - If v2 ≥ THRESH, fire:
    - membrane ← 0.
    - fire pulse ← 1.
    - SPIKE_CNT ← min(cnt+1, 255).
    - fired_sticky ← 1.
    - ref_cnt ← REFRACT.
    - Go to REFRACTORY, or stay in INTEGRATE if REFRACT = 0.
  - Otherwise membrane ← v2.
- THRESH = 0 fires on every INTEGRATE cycle.
- REFRACTORY:
  - membrane held at 0 and spike_in ignored.
  - ref_cnt decrements each edge; leave to INTEGRATE on the edge where ref_cnt goes 1→0.
  - Spikes are therefore ignored for exactly REFRACT cycles.
- Leak timer:
  - Free-running counter 0..LEAK_PER−1 while enabled.
  - leak_tick = 1 on the cycle the counter equals LEAK_PER−1, then it wraps to 0.
  - Ticks during REFRACTORY are discarded.
  - A write to LEAK_PER resets the counter to 0.
- Clearing enable:
  - → IDLE next edge; ref_cnt is cleared and membrane is kept.
  - Re-enabling returns to INTEGRATE.
- Config writes take effect on the edge after the write.
- A CTRL clear coincident with a fire leaves SPIKE_CNT = 1 and fired_sticky = 1 (fire wins).

## Timing
- Reset values:
  - membrane 0, SPIKE_CNT 0, fired_sticky 0, state INTEGRATE, leak counter 0, ref_cnt 0.
  - `uo_out` = 8'b0000_0100.
  - `data_out` follows `address` (reads WEIGHT = 20 at address 0).
- Latency: spike_in sampled at edge N that crosses threshold → `uo_out[0]` high from edge N to N+1 (one cycle).
- `uo_out[1]` high from the fire edge until the exit edge.
- Upstream spike_in is a level, so a held-high input counts once per cycle.
- Asserting reset mid-refractory or mid-integration returns all state to reset values immediately.

## Structure
- Package `lif_pkg`: register address localparams, reset-default constants, state enum (IDLE, INTEGRATE, REFRACTORY).
- Sub-module `lif_leak_timer`: period counter with enable, sync restart and `tick` output.
- The top level holds the register file, saturating arithmetic and the FSM.

## Test plan
- Defaults, LEAK_PER=0, spike_in held high → membrane 20, 40, 60, 80, then fire on the 5th edge. Expect 1-cycle `uo_out[0]`, membrane 0, spikes ignored for 4 cycles, SPIKE_CNT=1.
- WEIGHT=200, THRESH=255, two spikes → membrane 200, then 255 (saturated), fire on the 2nd spike.
- WEIGHT=50, LEAK=10, LEAK_PER=4, one spike then idle → membrane 50, then reduced by 10 every 4 cycles to 0, and it does not go below 0.
- REFRACT=0, THRESH=0, enable=1 → fire every cycle. SPIKE_CNT saturates at 255 after 255+ cycles, and `uo_out[1]` never rises.
- Write CTRL=0 mid-integration at membrane 60 → spikes ignored and membrane stays 60. Write CTRL=1 → integration resumes from 60.
- Assert rst_n low during refractory → `uo_out`=0x04, all read-only registers 0, config registers at defaults; a CTRL bit1 clear on the fire edge leaves SPIKE_CNT=1.
